// File: rtl/pong_match_controller_if.sv
// Signal bundle between the match controller and the game-logic/renderer side.
// The master side drives the events and the slave (controller) drives the commands and scores.
interface pong_match_controller_if #(
  parameter int SCORE_W = 4
);
  logic               frame_tick;
  logic               start;
  logic               miss_left;
  logic               miss_right;
  logic               run_enable;
  logic               ball_reset;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic               game_over;
  logic               winner;

  modport master (
    output frame_tick, start, miss_left, miss_right,
    input  run_enable, ball_reset, serve_dir, score_p1, score_p2, game_over, winner
  );

  modport slave (
    input  frame_tick, start, miss_left, miss_right,
    output run_enable, ball_reset, serve_dir, score_p1, score_p2, game_over, winner
  );
endinterface

// File: rtl/pong_match_controller.sv
// Pong match sequencer: serve timing, ball motion gating, score keeping and winner detection.
// All outputs are registered; reset is synchronous and active-low.
module pong_match_controller #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60,
  parameter int SCORE_W     = 4
) (
  input  logic                    clk_0,
  input  logic                    rst,
  pong_match_controller_if.slave  bus
);

  localparam int CNT_W = $clog2(SERVE_DELAY + 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] SERVE_WAIT = 2'd1;
  localparam logic [1:0] RALLY      = 2'd2;
  localparam logic [1:0] GAME_OVER  = 2'd3;

  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(SERVE_DELAY);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

  logic [1:0]         state;
  logic [CNT_W-1:0]   serve_cnt;
  logic               start_q;
  logic               start_rise;
  logic               run_enable_r;
  logic               ball_reset_r;
  logic               serve_dir_r;
  logic [SCORE_W-1:0] score_p1_r;
  logic [SCORE_W-1:0] score_p2_r;
  logic               game_over_r;
  logic               winner_r;
  logic [SCORE_W-1:0] p1_inc;
  logic [SCORE_W-1:0] p2_inc;

  always_comb begin
    start_rise = bus.start & ~start_q;
    p1_inc     = score_p1_r + 1'b1;
    p2_inc     = score_p2_r + 1'b1;
  end

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      state        <= IDLE;
      serve_cnt    <= '0;
      start_q      <= 1'b1;  // a button held through reset must not count as a press
      run_enable_r <= 1'b0;
      ball_reset_r <= 1'b0;
      serve_dir_r  <= 1'b0;
      score_p1_r   <= '0;
      score_p2_r   <= '0;
      game_over_r  <= 1'b0;
      winner_r     <= 1'b0;
    end else begin
      start_q      <= bus.start;
      ball_reset_r <= 1'b0;
      case (state)
        IDLE: begin
          run_enable_r <= 1'b0;
          if (start_rise) begin
            state        <= SERVE_WAIT;
            ball_reset_r <= 1'b1;
            serve_cnt    <= '0;
            serve_dir_r  <= 1'b0;
          end
        end
        SERVE_WAIT: begin
          run_enable_r <= 1'b0;
          if (bus.frame_tick && serve_cnt != CNT_MAX) begin
            serve_cnt <= serve_cnt + 1'b1;
            if (serve_cnt == CNT_LAST) begin
              state        <= RALLY;
              run_enable_r <= 1'b1;
            end
          end
        end
        RALLY: begin
          run_enable_r <= 1'b1;
          if (bus.miss_left || bus.miss_right) begin
            // A double miss scores nobody, so only single misses can end the match
            if (bus.miss_left && !bus.miss_right) begin
              score_p2_r  <= p2_inc;
              serve_dir_r <= 1'b0;
            end else if (bus.miss_right && !bus.miss_left) begin
              score_p1_r  <= p1_inc;
              serve_dir_r <= 1'b1;
            end
            run_enable_r <= 1'b0;
            if (bus.miss_left && !bus.miss_right && p2_inc == WIN_VAL) begin
              state       <= GAME_OVER;
              game_over_r <= 1'b1;
              winner_r    <= 1'b1;
            end else if (bus.miss_right && !bus.miss_left && p1_inc == WIN_VAL) begin
              state       <= GAME_OVER;
              game_over_r <= 1'b1;
              winner_r    <= 1'b0;
            end else begin
              state        <= SERVE_WAIT;
              ball_reset_r <= 1'b1;
              serve_cnt    <= '0;
            end
          end
        end
        GAME_OVER: begin
          run_enable_r <= 1'b0;
          if (start_rise) begin
            state        <= SERVE_WAIT;
            score_p1_r   <= '0;
            score_p2_r   <= '0;
            game_over_r  <= 1'b0;
            ball_reset_r <= 1'b1;
            serve_dir_r  <= 1'b0;
            serve_cnt    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.run_enable = run_enable_r;
  assign bus.ball_reset = ball_reset_r;
  assign bus.serve_dir  = serve_dir_r;
  assign bus.score_p1   = score_p1_r;
  assign bus.score_p2   = score_p2_r;
  assign bus.game_over  = game_over_r;
  assign bus.winner     = winner_r;

endmodule
